// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser: pattern mode encoding and bounce direction.
package led_chaser_pkg;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        ROT_L  = 2'd1,
        ROT_R  = 2'd2,
        FILL   = 2'd3
    } chase_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_chaser_gen_prescaler.sv
// Tick prescaler: emits step on every (speed+1)-th enabled tick; speed is read live.
module tick_prescaler #(
    parameter int SPD_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [SPD_W-1:0] speed,
    output logic             step
);

    logic [SPD_W-1:0] pre_cnt;

    // >= so that lowering speed below the running count fires on the next tick.
    always_comb step = en && (pre_cnt >= speed);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (step) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + SPD_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser_gen.sv
// Parametrised LED chaser with bounce/rotate/fill patterns, tick prescaler and end-of-sweep pulse.
// Optional two-LED comet trail when LED_CHASER_TRAIL_EN is defined.
module led_chaser_gen
    import led_chaser_pkg::*;
#(
    parameter int N_LEDS = 16,
    parameter int SPD_W  = 4,
    parameter int POS_W  = $clog2(N_LEDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic              m_tick,
    input  logic [1:0]        mode,
    input  logic [SPD_W-1:0]  speed,
    output logic [N_LEDS-1:0] led,
    output logic [POS_W-1:0]  pos,
    output logic              end_pulse
);

    localparam logic [POS_W-1:0]  LAST    = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]  FULL    = POS_W'(N_LEDS);
    localparam logic [N_LEDS-1:0] ONE_LED = N_LEDS'(1);

    chase_mode_t      mode_reg;
    logic             dir, dir_n;
    logic [POS_W-1:0] pos_n;
    logic             pulse_n;
    logic             mode_chg;
    logic             step;
    logic             do_step;

    assign mode_chg = (chase_mode_t'(mode) != mode_reg);
    assign do_step  = step && !mode_chg;

    tick_prescaler #(.SPD_W(SPD_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (mode_chg),
        .en    (m_tick && !stop),
        .speed (speed),
        .step  (step)
    );

`ifdef LED_CHASER_TRAIL_EN
    logic [POS_W-1:0] prev_pos, prev_n;

    always_comb begin
        prev_n = prev_pos;
        if (mode_chg)     prev_n = '0;
        else if (do_step) prev_n = pos;
    end

    always_ff @(posedge clk) begin
        if (!reset) prev_pos <= '0;
        else        prev_pos <= prev_n;
    end
`endif

    always_comb begin
        pos_n   = pos;
        dir_n   = dir;
        pulse_n = 1'b0;
        if (mode_chg) begin
            pos_n = '0;
            dir_n = DIR_UP;
        end else if (do_step) begin
            case (mode_reg)
                BOUNCE: begin
                    // Flip on landing so each end LED dwells for exactly one step.
                    if (dir == DIR_UP) begin
                        pos_n = pos + POS_W'(1);
                        if (pos_n == LAST) begin
                            dir_n   = DIR_DOWN;
                            pulse_n = 1'b1;
                        end
                    end else begin
                        pos_n = pos - POS_W'(1);
                        if (pos_n == '0) begin
                            dir_n   = DIR_UP;
                            pulse_n = 1'b1;
                        end
                    end
                end
                ROT_L: begin
                    if (pos == LAST) begin
                        pos_n   = '0;
                        pulse_n = 1'b1;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end
                ROT_R: begin
                    if (pos == '0) begin
                        pos_n   = LAST;
                        pulse_n = 1'b1;
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end
                default: begin
                    if (pos == FULL) begin
                        pos_n   = '0;
                        pulse_n = 1'b1;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos       <= '0;
            dir       <= DIR_UP;
            end_pulse <= 1'b0;
            mode_reg  <= BOUNCE;
        end else begin
            pos       <= pos_n;
            dir       <= dir_n;
            end_pulse <= pulse_n;
            mode_reg  <= chase_mode_t'(mode);
        end
    end

    // Shifting past the top yields zero, so level N_LEDS lights every LED.
    always_comb begin
        if (mode_reg == FILL) begin
            led = ~({N_LEDS{1'b1}} << pos);
        end else begin
`ifdef LED_CHASER_TRAIL_EN
            led = (ONE_LED << pos) | (ONE_LED << prev_pos);
`else
            led = ONE_LED << pos;
`endif
        end
    end

endmodule

// File: tb/tb_led_chaser_gen.sv
// Self-checking bench for led_chaser_gen: directed scenarios plus randomized traffic vs. a step-count model.
module tb_led_chaser_gen;

    localparam int N     = 16;
    localparam int SPD_W = 4;
    localparam int POS_W = $clog2(N + 1);

    logic             clk;
    logic             reset;
    logic             stop;
    logic             m_tick;
    logic [1:0]       mode;
    logic [SPD_W-1:0] speed;
    logic [N-1:0]     led;
    logic [POS_W-1:0] pos;
    logic             end_pulse;

    int checks = 0;
    int errors = 0;

    led_chaser_gen #(.N_LEDS(N), .SPD_W(SPD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .stop      (stop),
        .m_tick    (m_tick),
        .mode      (mode),
        .speed     (speed),
        .led       (led),
        .pos       (pos),
        .end_pulse (end_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the pattern is a pure function of steps taken since the last restart.
    int           m_mode  = 0;
    int           m_steps = 0;
    int           m_pre   = 0;
    bit           m_step_now = 0;
    int           e_pos   = 0;
    logic [N-1:0] e_led   = '0;
    logic         e_pulse = 1'b0;

    function automatic int ref_pos(int md, int k);
        int p;
        case (md)
            0: begin
                p = k % (2 * N - 2);
                return (p < N) ? p : (2 * N - 2 - p);
            end
            1: return k % N;
            2: return (N - (k % N)) % N;
            default: return k % (N + 1);
        endcase
    endfunction

    function automatic logic [N-1:0] ref_led(int md, int k);
        longint unsigned v;
        int p;
        p = ref_pos(md, k);
        if (md == 3) begin
            v = (64'd1 << p) - 64'd1;
        end else begin
            v = 64'd1 << p;
`ifdef LED_CHASER_TRAIL_EN
            if (k > 0) v = v | (64'd1 << ref_pos(md, k - 1));
`endif
        end
        return v[N-1:0];
    endfunction

    task automatic model_edge(input logic t, input logic s, input logic [1:0] md,
                              input int sp, input logic r);
        m_step_now = 0;
        if (!r) begin
            m_mode = 0; m_steps = 0; m_pre = 0;
        end else if (int'(md) != m_mode) begin
            m_mode = int'(md); m_steps = 0; m_pre = 0;
        end else if (t && !s) begin
            if (m_pre >= sp) begin
                m_steps++; m_pre = 0; m_step_now = 1;
            end else begin
                m_pre++;
            end
        end
        e_pos = ref_pos(m_mode, m_steps);
        e_led = ref_led(m_mode, m_steps);
        e_pulse = m_step_now && (
            (m_mode == 0 && (e_pos == 0 || e_pos == N - 1)) ||
            (m_mode == 1 && e_pos == 0) ||
            (m_mode == 2 && e_pos == N - 1) ||
            (m_mode == 3 && e_pos == 0));
    endtask

    // Driver: apply inputs mid-cycle, advance one clock, leave outputs settled for sampling.
    task automatic drive(input logic t, input logic s, input logic [1:0] md,
                         input int sp, input logic r);
        @(negedge clk);
        m_tick = t; stop = s; mode = md; speed = SPD_W'(sp); reset = r;
        @(posedge clk);
        model_edge(t, s, md, sp, r);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'd2, 0, 1'b0);
        checks++;
        if (pos !== POS_W'(0) || led !== N'(1) || end_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset: pos=%0d led=%h pulse=%b, want pos=0 led=0001 pulse=0", pos, led, end_pulse);
        end
        drive(1'b0, 1'b0, 2'd0, 0, 1'b1);
    endtask

    task automatic test_bounce();
        int pulses = 0;
        drive(1'b0, 1'b0, 2'd0, 0, 1'b0);
        for (int st = 0; st < 30; st++) begin
            for (int c = 0; c < 4; c++) begin
                drive(c == 3, 1'b0, 2'd0, 0, 1'b1);
                if (end_pulse === 1'b1) pulses++;
                checks++;
                if (pos !== POS_W'(e_pos) || led !== e_led || end_pulse !== e_pulse || led === '0) begin
                    errors++;
                    $display("FAIL bounce step %0d: pos=%0d led=%h pulse=%b, want pos=%0d led=%h pulse=%b",
                             st, pos, led, end_pulse, e_pos, e_led, e_pulse);
                end
            end
        end
        checks++;
        if (pulses != 2 || led !== N'(1)) begin
            errors++;
            $display("FAIL bounce_sweep: pulses=%0d led=%h, want 2 and 0001", pulses, led);
        end
    endtask

    task automatic test_rotate();
        int pulses = 0;
        drive(1'b0, 1'b0, 2'd1, 0, 1'b1);
        for (int st = 0; st < 16; st++) begin
            drive(1'b1, 1'b0, 2'd1, 0, 1'b1);
            if (end_pulse === 1'b1) pulses++;
            checks++;
            if (pos !== POS_W'(e_pos) || led !== e_led || end_pulse !== e_pulse) begin
                errors++;
                $display("FAIL rot_l step %0d: pos=%0d led=%h pulse=%b, want pos=%0d led=%h pulse=%b",
                         st, pos, led, end_pulse, e_pos, e_led, e_pulse);
            end
        end
        checks++;
        if (pulses != 1 || led !== N'(1)) begin
            errors++;
            $display("FAIL rot_l_wrap: pulses=%0d led=%h, want 1 and 0001", pulses, led);
        end
        drive(1'b0, 1'b0, 2'd2, 0, 1'b1);
        drive(1'b1, 1'b0, 2'd2, 0, 1'b1);
        checks++;
        if (led !== N'(16'h8000) || end_pulse !== 1'b1 || pos !== POS_W'(e_pos)) begin
            errors++;
            $display("FAIL rot_r_first: led=%h pulse=%b pos=%0d, want 8000 1 %0d", led, end_pulse, pos, e_pos);
        end
    endtask

    task automatic test_fill();
        drive(1'b0, 1'b0, 2'd3, 0, 1'b1);
        checks++;
        if (led !== '0) begin
            errors++;
            $display("FAIL fill_empty: led=%h, want 0000", led);
        end
        for (int st = 1; st <= 18; st++) begin
            drive(1'b1, 1'b0, 2'd3, 0, 1'b1);
            checks++;
            if (pos !== POS_W'(e_pos) || led !== e_led || end_pulse !== e_pulse) begin
                errors++;
                $display("FAIL fill step %0d: pos=%0d led=%h pulse=%b, want pos=%0d led=%h pulse=%b",
                         st, pos, led, end_pulse, e_pos, e_led, e_pulse);
            end
            if (st == 16) begin
                checks++;
                if (led !== '1) begin
                    errors++;
                    $display("FAIL fill_full: led=%h, want ffff", led);
                end
            end
        end
    endtask

    task automatic test_prescaler_stop();
        logic [POS_W-1:0] frozen;
        drive(1'b0, 1'b0, 2'd0, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 2'd0, 3, 1'b1);
            checks++;
            if (pos !== POS_W'(e_pos) || end_pulse !== e_pulse) begin
                errors++;
                $display("FAIL speed3 tick %0d: pos=%0d pulse=%b, want %0d %b", i, pos, end_pulse, e_pos, e_pulse);
            end
        end
        frozen = pos;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 2'd0, 3, 1'b1);
            checks++;
            if (pos !== frozen) begin
                errors++;
                $display("FAIL stop_hold %0d: pos=%0d, want %0d", i, pos, frozen);
            end
        end
        // Two ticks remain in the count before the next step.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0, 3, 1'b1);
            checks++;
            if (pos !== POS_W'(e_pos)) begin
                errors++;
                $display("FAIL stop_resume %0d: pos=%0d, want %0d", i, pos, e_pos);
            end
        end
        drive(1'b1, 1'b0, 2'd0, 3, 1'b1);
        drive(1'b1, 1'b0, 2'd0, 3, 1'b1);
        drive(1'b1, 1'b0, 2'd0, 0, 1'b1);
        checks++;
        if (pos !== POS_W'(e_pos) || pos !== POS_W'(3)) begin
            errors++;
            $display("FAIL speed_lowered: pos=%0d, want %0d", pos, e_pos);
        end
    endtask

    task automatic test_mode_switch();
        drive(1'b0, 1'b0, 2'd1, 0, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 0, 1'b1);
        for (int i = 0; i < 21; i++) drive(1'b1, 1'b0, 2'd0, 0, 1'b1);
        checks++;
        if (pos !== POS_W'(9) || pos !== POS_W'(e_pos)) begin
            errors++;
            $display("FAIL bounce_down9: pos=%0d, want 9", pos);
        end
        drive(1'b1, 1'b0, 2'd1, 0, 1'b1);
        checks++;
        if (pos !== POS_W'(0) || led !== N'(1) || end_pulse !== 1'b0) begin
            errors++;
            $display("FAIL switch_rot_l: pos=%0d led=%h pulse=%b, want 0 0001 0", pos, led, end_pulse);
        end
        drive(1'b1, 1'b0, 2'd1, 0, 1'b1);
        checks++;
        if (pos !== POS_W'(1) || led !== e_led) begin
            errors++;
            $display("FAIL switch_first_step: pos=%0d led=%h, want 1 %h", pos, led, e_led);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 2'd3, 0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 2'd3, 0, 1'b1);
        checks++;
        if (pos !== POS_W'(7) || led !== N'(16'h007f)) begin
            errors++;
            $display("FAIL fill_level7: pos=%0d led=%h, want 7 007f", pos, led);
        end
        drive(1'b1, 1'b1, 2'd3, 0, 1'b0);
        checks++;
        if (pos !== POS_W'(0) || led !== N'(1) || end_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pos=%0d led=%h pulse=%b, want 0 0001 0", pos, led, end_pulse);
        end
`ifdef LED_CHASER_TRAIL_EN
        drive(1'b0, 1'b0, 2'd0, 0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd0, 0, 1'b1);
        checks++;
        if (led !== N'(16'h0060)) begin
            errors++;
            $display("FAIL trail_5_6: led=%h, want 0060", led);
        end
`endif
    endtask

    task automatic test_random();
        logic [1:0] md = 2'd0;
        int sp = 0;
        drive(1'b0, 1'b0, 2'd0, 0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) sp = $urandom_range(0, 3);
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, md, sp,
                  $urandom_range(0, 299) != 0);
            checks++;
            if (pos !== POS_W'(e_pos) || led !== e_led || end_pulse !== e_pulse) begin
                errors++;
                $display("FAIL random cyc %0d: pos=%0d led=%h pulse=%b, want pos=%0d led=%h pulse=%b",
                         i, pos, led, end_pulse, e_pos, e_led, e_pulse);
            end
        end
    endtask

    initial begin
        reset = 1'b0; stop = 1'b0; m_tick = 1'b0; mode = 2'd0; speed = '0;
        test_reset();
        test_bounce();
        test_rotate();
        test_fill();
        test_prescaler_stop();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
